temporizador_irrigacao: RTL and testbench
=========================================

Name: temporizador_irrigacao

Overview:
Two-digit BCD countdown timer that sets how long the irrigation valve stays open. It sits downstream of the single-digit BCD down-counter stage. It chains a units digit and a tens digit with borrow propagation, and paces the countdown with an internal clock prescaler. A start/pause/abort control FSM drives the valve output, the busy flag and a one-cycle done pulse for the zone sequencer.

Parameters:
DIV, 10, clk cycles per countdown step (valid range 2..2^24); tests use DIV=4
CNT_W, 24, prescaler counter width; must satisfy 2^CNT_W >= DIV

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  level, sampled each edge; starts a run from IDLE
pause  input  1  level; holds the countdown while high
abort  input  1  level; cancels the run
dur_tens  input  4  BCD tens digit of duration (steps)
dur_units  input  4  BCD units digit of duration (steps)
tens  output  4  current tens digit, BCD
units  output  4  current units digit, BCD
valve  output  1  valve drive, registered
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse on natural completion
state  output  3  FSM state code, for debug

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tens=0, units=0, prescaler=0, valve=0, busy=0, done=0. This holds even mid-run; there is no done pulse on reset.
- State encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3; codes 4..7 are illegal and recover to IDLE on the next edge.
- Priority at every edge: abort > pause > prescaler tick. start is honoured only in IDLE.
- IDLE:
  - start=1 and abort=0 loads tens/units from dur_tens/dur_units. Any digit above 9 clamps to 9. The prescaler clears.
  - If the loaded value is nonzero, next state is RUN. If it is 00, next state is DONE.
- RUN:
  - Prescaler increments each cycle. tick = (prescaler == DIV-1), after which the prescaler wraps to 0.
  - On tick: if units != 0, units decrements; else units=9 and tens decrements (borrow).
  - If the post-decrement value is 00, go to DONE on the same edge.
  - pause=1 goes to PAUSE with the prescaler and digits held; a tick coinciding with pause is dropped.
- PAUSE: nothing changes. pause=0 returns to RUN and the prescaler resumes from its held value.
- DONE: lasts exactly one cycle, then IDLE. Digits stay 00. If start is high in DONE, it is ignored; a new run needs start still/again high while in IDLE.
- abort=1 in any state goes to IDLE with digits 00, prescaler 0 and no done pulse.
- Registered outputs, updated on the same edge as the state:
  - valve = (next state == RUN)
  - busy = (next state is RUN or PAUSE)
  - done = (next state == DONE)
- Timing:
  - Uninterrupted run of N steps: valve is high for exactly N*DIV cycles, starting the cycle after start is sampled.
  - done asserts on the edge where valve falls.
  - Pauses extend the total time but never change the number of valve-high cycles.
- Width rules:
  - Digits always stay in 0..9.
  - The borrow out of tens never occurs, because 00 is caught first.

Test Plan:
- Reset mid-run: DIV=4, start with 3/5, pull rst low at cycle 20 -> all outputs 0 immediately (asynchronous); after release, state stays IDLE with no done pulse.
- Normal run, DIV=4, dur 1/2 -> valve high 48 cycles; digits 12,11,10,09 (borrow at cycle 12),…,01; done=1 for one cycle; digits 00; valve 0; then IDLE.
- Pause: same run with pause high for 10 cycles while at 07 -> valve low, digits held at 07 during PAUSE; valve-high total still 48; done 10 cycles later than without pause.
- Abort: same run with abort pulsed at value 05 -> next edge IDLE, digits 00, valve 0, done never asserts; simultaneous pause+abort -> abort wins.
- Zero/invalid load: dur 0/0 -> done one cycle after start, valve never high. dur 0xC/0x3 -> loads 9/3 and valve is high 93*DIV cycles.
- start while busy: re-assert start with new dur 0/1 during RUN -> ignored, original countdown continues unchanged.

Source files
------------

// File: rtl/temporizador_irrigacao_if.sv
// Control and display bundle of the irrigation timer.
// Handshake: level-sensitive controls. The master holds start/pause/abort and
// the duration digits stable around each rising clk edge; the slave samples
// them on that edge and returns registered status on the same edge.
// There is no ready signal: the slave accepts control on every edge.
interface temporizador_irrigacao_if;
   logic       start;
   logic       pause;
   logic       abort;
   logic [3:0] dur_tens;
   logic [3:0] dur_units;
   logic [3:0] tens;
   logic [3:0] units;
   logic       valve;
   logic       busy;
   logic       done;
   logic [2:0] state;

   modport master (
      output start, pause, abort, dur_tens, dur_units,
      input  tens, units, valve, busy, done, state
   );

   modport slave (
      input  start, pause, abort, dur_tens, dur_units,
      output tens, units, valve, busy, done, state
   );
endinterface

// File: rtl/temporizador_irrigacao.sv
// Two-digit BCD countdown that keeps the irrigation valve open for a set
// number of prescaled steps, with start/pause/abort control and a one-cycle
// done pulse for the zone sequencer.
module temporizador_irrigacao #(
   parameter int DIV   = 10,
   parameter int CNT_W = 24
) (
   input logic                     clk,
   input logic                     rst,
   temporizador_irrigacao_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      DONE  = 3'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   state_t           st;
   logic [CNT_W-1:0] presc;
   logic [3:0]       tens_q;
   logic [3:0]       units_q;
   logic             valve_q;
   logic             busy_q;
   logic             done_q;

   logic             tick;
   logic             last_step;
   logic [3:0]       dec_tens;
   logic [3:0]       dec_units;

   // Digits above 9 on the duration inputs are treated as 9.
   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // One step down of the two-digit value, borrowing from tens when units is 0.
   // The value 01 is the last step; 00 never reaches the decrement, so tens
   // cannot underflow.
   always_comb begin
      tick      = (presc == LAST);
      last_step = (tens_q == 4'd0) && (units_q == 4'd1);
      dec_tens  = tens_q;
      dec_units = units_q - 4'd1;
      if (units_q == 4'd0) begin
         dec_tens  = tens_q - 4'd1;
         dec_units = 4'd9;
      end
   end

   // Control FSM; valve/busy/done are registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st      <= IDLE;
         presc   <= '0;
         tens_q  <= 4'd0;
         units_q <= 4'd0;
         valve_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.abort) begin
            st      <= IDLE;
            presc   <= '0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            valve_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  if (bus.start) begin
                     tens_q  <= clamp9(bus.dur_tens);
                     units_q <= clamp9(bus.dur_units);
                     presc   <= '0;
                     if (bus.dur_tens == 4'd0 && bus.dur_units == 4'd0) begin
                        st      <= DONE;
                        done_q  <= 1'b1;
                        valve_q <= 1'b0;
                        busy_q  <= 1'b0;
                     end else begin
                        st      <= RUN;
                        valve_q <= 1'b1;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               // Releasing pause counts as a run cycle, so pausing never
               // changes the number of valve-high cycles.
               RUN, PAUSE: begin
                  if (bus.pause) begin
                     st      <= PAUSE;
                     valve_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end else if (tick) begin
                     presc   <= '0;
                     tens_q  <= dec_tens;
                     units_q <= dec_units;
                     if (last_step) begin
                        st      <= DONE;
                        done_q  <= 1'b1;
                        valve_q <= 1'b0;
                        busy_q  <= 1'b0;
                     end else begin
                        st      <= RUN;
                        valve_q <= 1'b1;
                        busy_q  <= 1'b1;
                     end
                  end else begin
                     presc   <= presc + 1'b1;
                     st      <= RUN;
                     valve_q <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end
               DONE: begin
                  st      <= IDLE;
                  valve_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
               default: begin
                  st      <= IDLE;
                  presc   <= '0;
                  tens_q  <= 4'd0;
                  units_q <= 4'd0;
                  valve_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.tens  = tens_q;
   assign bus.units = units_q;
   assign bus.valve = valve_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.state = st;

endmodule

// File: tb/tb_temporizador_irrigacao.sv
// Bench for the irrigation countdown timer: directed scenarios with literal
// timing expectations, then randomized control, all shadowed by an
// integer-valued behavioural model and compared every cycle.
module tb_temporizador_irrigacao;
   localparam int DIV = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   temporizador_irrigacao_if bus();

   temporizador_irrigacao #(.DIV(DIV), .CNT_W(24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc_no = 0;
   int valve_cnt = 0;
   int done_cnt = 0;

   always @(posedge clk) cyc_no++;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 running, 2 paused, 3 done pulse; value held as an integer.
   logic [14:0] exp_q[$];
   int m_mode = 0;
   int m_val = 0;
   int m_phase = 0;

   function automatic int clampd(input logic [3:0] d);
      return (d > 9) ? 9 : int'(d);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = 0;
         m_val = 0;
         m_phase = 0;
         exp_q.delete();
      end else begin
         if (bus.abort) begin
            m_mode = 0;
            m_val = 0;
            m_phase = 0;
         end else if (m_mode == 0) begin
            if (bus.start) begin
               m_val = clampd(bus.dur_tens) * 10 + clampd(bus.dur_units);
               m_phase = 0;
               m_mode = (m_val == 0) ? 3 : 1;
            end
         end else if (m_mode == 3) begin
            m_mode = 0;
         end else if (bus.pause) begin
            m_mode = 2;
         end else begin
            m_phase++;
            m_mode = 1;
            if (m_phase == DIV) begin
               m_phase = 0;
               m_val--;
               if (m_val == 0) m_mode = 3;
            end
         end
         exp_q.push_back({3'(m_mode), 4'(m_val / 10), 4'(m_val % 10),
                          m_mode == 1, (m_mode == 1) || (m_mode == 2), m_mode == 3});
      end
   end

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [14:0] act;
      logic [14:0] e;
      act = {bus.state, bus.tens, bus.units, bus.valve, bus.busy, bus.done};
      if (!rst) begin
         check("reset_outputs", act, 15'd0);
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", act, e);
         end
         if (bus.valve) valve_cnt++;
         if (bus.done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic launch(input logic [3:0] t, input logic [3:0] u, output int s);
      bus.dur_tens = t;
      bus.dur_units = u;
      bus.start = 1'b1;
      s = cyc_no;
      step(1);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            at = cyc_no;
            break;
         end
      end
      step(1);
   endtask

   task automatic wait_value(input logic [3:0] t, input logic [3:0] u, input int limit);
      bit seen;
      seen = 0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (bus.tens == t && bus.units == u) begin
            seen = 1;
            break;
         end
      end
      check("wait_value_reached", seen, 1);
      step(1);
   endtask

   task automatic clear_counts();
      valve_cnt = 0;
      done_cnt = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int s;
      int at;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      bus.dur_tens = 4'd0;
      bus.dur_units = 4'd0;
      step(3);
      rst = 1'b1;
      step(2);
      check("idle_state", bus.state, 0);

      // Normal run 12 steps: 48 valve cycles, done 48 cycles after the start edge.
      clear_counts();
      launch(4'd1, 4'd2, s);
      step(12);
      check("borrow_to_09", {bus.tens, bus.units}, 8'h09);
      wait_done(200, at);
      check("normal_done_time", at, s + 1 + 48);
      check("normal_valve_cycles", valve_cnt, 48);
      check("normal_done_count", done_cnt, 1);
      check("normal_digits_00", {bus.tens, bus.units}, 8'h00);

      // Pause 10 cycles at 07.
      step(3);
      clear_counts();
      launch(4'd1, 4'd2, s);
      wait_value(4'd0, 4'd7, 100);
      bus.pause = 1'b1;
      step(5);
      check("pause_hold", {bus.state, bus.tens, bus.units, bus.valve, bus.busy},
            {3'd2, 4'd0, 4'd7, 1'b0, 1'b1});
      step(5);
      bus.pause = 1'b0;
      wait_done(200, at);
      check("pause_done_time", at, s + 1 + 48 + 10);
      check("pause_valve_cycles", valve_cnt, 48);

      // Abort at 05 together with pause: abort wins.
      step(3);
      clear_counts();
      launch(4'd1, 4'd2, s);
      wait_value(4'd0, 4'd5, 100);
      bus.abort = 1'b1;
      bus.pause = 1'b1;
      step(1);
      bus.abort = 1'b0;
      bus.pause = 1'b0;
      check("abort_outputs", {bus.state, bus.tens, bus.units, bus.valve, bus.busy},
            {3'd0, 4'd0, 4'd0, 1'b0, 1'b0});
      step(60);
      check("abort_no_done", done_cnt, 0);

      // Zero load: done right after start, valve never opens.
      clear_counts();
      launch(4'd0, 4'd0, s);
      wait_done(10, at);
      check("zero_done_time", at, s + 1);
      check("zero_valve_cycles", valve_cnt, 0);

      // Invalid digits clamp: C/3 loads 9/3.
      step(2);
      clear_counts();
      launch(4'hC, 4'h3, s);
      step(1);
      check("clamp_load", {bus.tens, bus.units}, 8'h93);
      wait_done(400, at);
      check("clamp_done_time", at, s + 1 + 93 * DIV);
      check("clamp_valve_cycles", valve_cnt, 93 * DIV);

      // start while busy is ignored.
      step(2);
      clear_counts();
      launch(4'd1, 4'd2, s);
      step(10);
      bus.dur_tens = 4'd0;
      bus.dur_units = 4'd1;
      bus.start = 1'b1;
      step(3);
      bus.start = 1'b0;
      wait_done(200, at);
      check("restart_ignored_time", at, s + 1 + 48);
      check("restart_ignored_valve", valve_cnt, 48);

      // Asynchronous reset mid-run.
      step(2);
      clear_counts();
      launch(4'd3, 4'd5, s);
      step(19);
      check("pre_reset_valve", bus.valve, 1);
      rst = 1'b0;
      #1;
      check("async_reset_outputs",
            {bus.state, bus.tens, bus.units, bus.valve, bus.busy, bus.done}, 15'd0);
      step(2);
      rst = 1'b1;
      clear_counts();
      step(10);
      check("post_reset_idle", bus.state, 0);
      check("post_reset_no_done", done_cnt, 0);

      // Randomized control against the model.
      for (int i = 0; i < 1500; i++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.pause = ($urandom_range(0, 7) == 0);
         bus.abort = ($urandom_range(0, 60) == 0);
         bus.dur_tens = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 1));
         bus.dur_units = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 400) == 0) ? 1'b0 : 1'b1;
         step(1);
      end
      rst = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
